// File: rtl/id_pkg.sv
// Shared constants and types for the instruction decode stage.
package id_pkg;

  localparam int REG_W = 4;
  localparam int IMM_W = 16;
  localparam int OPC_W = 7;

  // Instruction field positions (LSB of each field)
  localparam int OPC_LSB = 25;
  localparam int RD_LSB  = 21;
  localparam int RS1_LSB = 17;
  localparam int RS2_LSB = 13;

  localparam logic [OPC_W-1:0] OPC_NOP = 7'b1100100;
  localparam logic [OPC_W-1:0] OPC_B   = 7'b1100000;

  typedef enum logic [1:0] {
    CLS_ALU_RR  = 2'b00,
    CLS_ALU_IMM = 2'b01,
    CLS_MEM     = 2'b10,
    CLS_CTRL    = 2'b11
  } opc_class_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic is_branch;
    logic use_imm;
  } ctrl_t;

  // Class lives in the two most significant opcode bits
  function automatic opc_class_e opc_class(input logic [OPC_W-1:0] opc);
    return opc_class_e'(opc[OPC_W-1 -: 2]);
  endfunction

endpackage

// File: rtl/id_decode_stage_ctrl_decode.sv
// Purely combinational opcode to control-flag decode.
module id_ctrl_decode
  import id_pkg::*;
#(
  parameter logic [OPC_W-1:0] NOP_OPC = OPC_NOP
) (
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  // Map opcode class (and load/store bit) onto control flags
  always_comb begin
    ctrl = '0;
    unique case (opc_class(opcode))
      CLS_ALU_RR: begin
        ctrl.reg_write = 1'b1;
      end
      CLS_ALU_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
      end
      CLS_MEM: begin
        ctrl.use_imm = 1'b1;
        if (opcode[0]) begin
          ctrl.mem_write = 1'b1;
        end else begin
          ctrl.mem_read  = 1'b1;
          ctrl.reg_write = 1'b1;
        end
      end
      CLS_CTRL: begin
        // NOP lives in the control class but must not look like a branch
        if (opcode != NOP_OPC) begin
          ctrl.is_branch = 1'b1;
          ctrl.use_imm   = 1'b1;
        end
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// Decode stage: IF/ID latch, field split and flag decode into ID/EX,
// load-use bubble insertion and EXE-redirect squash.
module id_decode_stage #(
  parameter int               REG_W   = id_pkg::REG_W,
  parameter int               IMM_W   = id_pkg::IMM_W,
  parameter logic [6:0]       NOP_OPC = id_pkg::OPC_NOP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  input  logic             exeOverride,
  input  logic             exe_hold,
  output logic             stall_fetch,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [6:0]       id_opcode,
  output logic [REG_W-1:0] id_rd,
  output logic [REG_W-1:0] id_rs1,
  output logic [REG_W-1:0] id_rs2,
  output logic [31:0]      id_imm,
  output logic             id_reg_write,
  output logic             id_mem_read,
  output logic             id_mem_write,
  output logic             id_is_branch,
  output logic             id_use_imm
);
  import id_pkg::*;

  logic             ifid_valid;
  logic [31:0]      ifid_pc;
  logic [31:0]      ifid_instr;

  logic [6:0]       dec_opc;
  logic [REG_W-1:0] dec_rd;
  logic [REG_W-1:0] dec_rs1;
  logic [REG_W-1:0] dec_rs2;
  logic [31:0]      dec_imm;
  ctrl_t            dec_ctrl;
  opc_class_e       dec_cls;
  logic             reads_rs1;
  logic             reads_rs2;
  logic             hazard;

  assign dec_opc = ifid_instr[OPC_LSB +: 7];
  assign dec_rd  = ifid_instr[RD_LSB  +: REG_W];
  assign dec_rs1 = ifid_instr[RS1_LSB +: REG_W];
  assign dec_rs2 = ifid_instr[RS2_LSB +: REG_W];
  assign dec_imm = {{(32-IMM_W){ifid_instr[IMM_W-1]}}, ifid_instr[IMM_W-1:0]};

  id_ctrl_decode #(
    .NOP_OPC (NOP_OPC)
  ) u_ctrl (
    .opcode (dec_opc),
    .ctrl   (dec_ctrl)
  );

  // Load-use hazard: only sources the instruction really reads count; r0 never does
  always_comb begin
    dec_cls   = opc_class(dec_opc);
    reads_rs1 = (dec_cls != CLS_CTRL);
    reads_rs2 = (dec_cls == CLS_ALU_RR) || dec_ctrl.mem_write;
    hazard    = ifid_valid && id_valid && id_mem_read && (id_rd != '0) &&
                ((reads_rs1 && (dec_rs1 == id_rd)) ||
                 (reads_rs2 && (dec_rs2 == id_rd)));
  end

  // Redirect wins over hold/hazard so fetch can take the new PC at once
  assign stall_fetch = !rst && !exeOverride && (exe_hold || hazard);

  // IF/ID latch: load when fetch is not stalled, squash on redirect
  always_ff @(posedge clk) begin
    if (rst || exeOverride) begin
      ifid_valid <= 1'b0;
      if (rst) begin
        ifid_pc    <= '0;
        ifid_instr <= '0;
      end
    end else if (!stall_fetch) begin
      ifid_valid <= if_valid;
      if (if_valid) begin
        ifid_pc    <= if_pc;
        ifid_instr <= if_instr;
      end
    end
  end

  // ID/EX latch: frozen on hold, bubble on hazard or empty IF/ID
  always_ff @(posedge clk) begin
    if (rst || exeOverride || (!exe_hold && (hazard || !ifid_valid))) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_opcode    <= '0;
      id_rd        <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_imm       <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_is_branch <= 1'b0;
      id_use_imm   <= 1'b0;
    end else if (!exe_hold) begin
      id_valid     <= 1'b1;
      id_pc        <= ifid_pc;
      id_opcode    <= dec_opc;
      id_rd        <= dec_rd;
      id_rs1       <= dec_rs1;
      id_rs2       <= dec_rs2;
      id_imm       <= dec_imm;
      id_reg_write <= dec_ctrl.reg_write;
      id_mem_read  <= dec_ctrl.mem_read;
      id_mem_write <= dec_ctrl.mem_write;
      id_is_branch <= dec_ctrl.is_branch;
      id_use_imm   <= dec_ctrl.use_imm;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed scenarios plus a random run
// against a behavioural pipeline model.
module tb_id_decode_stage;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst, if_valid, exeOverride, exe_hold;
  logic [31:0] if_pc, if_instr;
  logic        stall_fetch, id_valid;
  logic [31:0] id_pc, id_imm;
  logic [6:0]  id_opcode;
  logic [3:0]  id_rd, id_rs1, id_rs2;
  logic        id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_use_imm;

  id_decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .exeOverride(exeOverride), .exe_hold(exe_hold), .stall_fetch(stall_fetch),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_is_branch(id_is_branch), .id_use_imm(id_use_imm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [3:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        rw, mr, mw, br, ui;
  } exp_t;

  int total = 0;
  int bad   = 0;

  // model state
  exp_t        m_id;
  logic        m_ifv;
  logic [31:0] m_ifpc, m_ifinstr;

  // bench-side fetch unit
  logic        rst_i, ovr_i, hold_i, fv_i;
  int          f_idx, f_len;
  logic [31:0] f_base;
  logic [31:0] prog [64];
  bit          sf_dut, sf_exp;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic [12:0] lo);
    return {op, rd, rs1, rs2, lo};
  endfunction

  function automatic exp_t decode(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    logic [6:0] op;
    e = '0;
    op = instr[31:25];
    e.valid = 1'b1;
    e.pc = pc;
    e.opcode = op;
    e.rd = instr[24:21];
    e.rs1 = instr[20:17];
    e.rs2 = instr[16:13];
    e.imm = {16'h0, instr[15:0]};
    if (instr[15]) e.imm = e.imm - 32'h0001_0000;
    if (op != OPC_NOP) begin
      case (op[6:5])
        2'd0: e.rw = 1;
        2'd1: begin e.rw = 1; e.ui = 1; end
        2'd2: if (op[0]) begin e.mw = 1; e.ui = 1; end
              else begin e.mr = 1; e.rw = 1; e.ui = 1; end
        default: begin e.br = 1; e.ui = 1; end
      endcase
    end
    return e;
  endfunction

  function automatic bit m_reads(input logic [31:0] instr, input logic [3:0] r);
    int cls;
    bit store;
    cls = int'(instr[31:30]);
    store = (cls == 2) && instr[25];
    return ((cls != 3) && (instr[20:17] == r)) ||
           (((cls == 0) || store) && (instr[16:13] == r));
  endfunction

  function bit m_haz();
    return m_ifv && m_id.valid && m_id.mr && (m_id.rd != 0) && m_reads(m_ifinstr, m_id.rd);
  endfunction

  function bit m_stall();
    if (rst_i || ovr_i) return 1'b0;
    return hold_i || m_haz();
  endfunction

  function exp_t dut_vec();
    return {id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_imm,
            id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_use_imm};
  endfunction

  task automatic model_step();
    bit haz;
    if (rst_i || ovr_i) begin
      m_ifv = 0;
      m_id = '0;
    end else begin
      haz = m_haz();
      if (!hold_i) m_id = haz ? exp_t'(0) : (m_ifv ? decode(m_ifpc, m_ifinstr) : exp_t'(0));
      if (!(hold_i || haz)) begin
        m_ifv = if_valid;
        if (if_valid) begin
          m_ifpc = if_pc;
          m_ifinstr = if_instr;
        end
      end
    end
  endtask

  // one clock: drive, sample stall before the edge, advance model, settle after edge
  task automatic cycle();
    bit acc;
    if_valid    = fv_i && (f_idx < f_len);
    if_pc       = f_base + 32'(f_idx) * 32'd4;
    if_instr    = (f_idx < f_len) ? prog[f_idx] : 32'h0;
    rst         = rst_i;
    exeOverride = ovr_i;
    exe_hold    = hold_i;
    #1;
    sf_dut = stall_fetch;
    sf_exp = m_stall();
    acc = !rst_i && !ovr_i && !sf_exp && if_valid;
    @(posedge clk);
    model_step();
    if (acc) f_idx++;
    #1;
  endtask

  task automatic restart(input logic [31:0] base, input int len);
    rst_i = 1; ovr_i = 0; hold_i = 0; fv_i = 1;
    cycle();
    rst_i = 0;
    f_idx = 0; f_base = base; f_len = len;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_i = 1; ovr_i = 0; hold_i = 0; fv_i = 1;
    f_idx = 0; f_len = 4; f_base = 32'h100;
    prog[0] = mk(7'b0100011, 4'd7, 4'd2, 4'd0, 13'h0123);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (dut_vec() !== exp_t'(0)) begin
        bad++; $display("FAIL reset_outputs cyc%0d: got %h want 0", i, dut_vec());
      end
      total++;
      if (sf_dut !== 1'b0) begin
        bad++; $display("FAIL reset_stall cyc%0d: got %b want 0", i, sf_dut);
      end
    end
    rst_i = 0;
    cycle();
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL reset_latency_early: id_valid got %b want 0", id_valid);
    end
    cycle();
    e = decode(32'h100, prog[0]);
    total++;
    if (dut_vec() !== e) begin
      bad++; $display("FAIL reset_first_instr: got %h want %h", dut_vec(), e);
    end
  endtask

  task automatic test_alu_imm();
    restart(32'h8, 1);
    prog[0] = 32'h4A2A_0010;
    cycle();
    cycle();
    total++;
    if ({id_valid, id_pc, id_opcode, id_rd, id_rs1, id_imm} !==
        {1'b1, 32'h8, 7'h25, 4'd1, 4'd5, 32'h0000_0010}) begin
      bad++; $display("FAIL alu_imm_fields: got v%b pc%h op%h rd%0d rs1%0d imm%h want v1 pc8 op25 rd1 rs1 5 imm10",
                      id_valid, id_pc, id_opcode, id_rd, id_rs1, id_imm);
    end
    total++;
    if ({id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_use_imm} !== 5'b10001) begin
      bad++; $display("FAIL alu_imm_flags: got %b want 10001",
                      {id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_use_imm});
    end
  endtask

  task automatic test_load_use();
    int stalls;
    stalls = 0;
    restart(32'h200, 3);
    prog[0] = mk(7'b1000000, 4'd3, 4'd1, 4'd0, 13'd4);
    prog[1] = mk(7'b0000000, 4'd4, 4'd1, 4'd3, 13'd0);
    prog[2] = mk(7'b0100000, 4'd5, 4'd2, 4'd0, 13'd7);
    for (int c = 1; c <= 6; c++) begin
      cycle();
      if (sf_dut) stalls++;
      total++;
      if (sf_dut !== sf_exp || dut_vec() !== m_id) begin
        bad++; $display("FAIL load_use_model c%0d: got sf%b %h want sf%b %h", c, sf_dut, dut_vec(), sf_exp, m_id);
      end
      if (c == 3) begin
        total++;
        if (sf_dut !== 1'b1 || id_valid !== 1'b0) begin
          bad++; $display("FAIL load_use_bubble: got sf%b v%b want sf1 v0", sf_dut, id_valid);
        end
      end
      if (c == 4) begin
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h204) begin
          bad++; $display("FAIL load_use_dependent: got v%b pc%h want v1 pc204", id_valid, id_pc);
        end
      end
    end
    total++;
    if (stalls !== 1) begin
      bad++; $display("FAIL load_use_stall_count: got %0d want 1", stalls);
    end
  endtask

  task automatic test_load_r0();
    int stalls;
    stalls = 0;
    restart(32'h300, 2);
    prog[0] = mk(7'b1000000, 4'd0, 4'd1, 4'd0, 13'd4);
    prog[1] = mk(7'b0000000, 4'd4, 4'd0, 4'd0, 13'd0);
    for (int c = 1; c <= 3; c++) begin
      cycle();
      if (sf_dut) stalls++;
    end
    total++;
    if (stalls !== 0 || id_valid !== 1'b1 || id_pc !== 32'h304) begin
      bad++; $display("FAIL load_r0: got stalls%0d v%b pc%h want stalls0 v1 pc304", stalls, id_valid, id_pc);
    end
  endtask

  task automatic test_override_in_stall();
    restart(32'h400, 9);
    prog[0] = mk(7'b1000000, 4'd3, 4'd1, 4'd0, 13'd4);
    prog[1] = mk(7'b0000000, 4'd4, 4'd1, 4'd3, 13'd0);
    prog[2] = mk(7'b0100000, 4'd5, 4'd2, 4'd0, 13'd7);
    prog[8] = mk(7'b0100001, 4'd6, 4'd3, 4'd0, 13'h1F0);
    cycle();
    cycle();
    ovr_i = 1;
    cycle();
    ovr_i = 0;
    f_idx = 8;
    total++;
    if (sf_dut !== 1'b0 || id_valid !== 1'b0) begin
      bad++; $display("FAIL override_squash: got sf%b v%b want sf0 v0", sf_dut, id_valid);
    end
    cycle();
    total++;
    if (sf_dut !== 1'b0 || id_valid !== 1'b0) begin
      bad++; $display("FAIL override_refetch: got sf%b v%b want sf0 v0", sf_dut, id_valid);
    end
    cycle();
    total++;
    if (sf_dut !== 1'b0 || dut_vec() !== decode(32'h420, prog[8])) begin
      bad++; $display("FAIL override_redirect: got sf%b %h want sf0 %h", sf_dut, dut_vec(), decode(32'h420, prog[8]));
    end
  endtask

  task automatic test_hold_nop_b();
    exp_t snap;
    restart(32'h500, 4);
    prog[0] = {OPC_NOP, 9'h0, 16'hFFFC};
    prog[1] = {OPC_B,   9'h0, 16'hFFFC};
    prog[2] = {OPC_NOP, 9'h0, 16'hFFFC};
    prog[3] = {OPC_B,   9'h0, 16'hFFFC};
    cycle();
    cycle();
    snap = dut_vec();
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h500 ||
        {id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_use_imm} !== 5'b0) begin
      bad++; $display("FAIL hold_nop_flags: got v%b pc%h flags%b want v1 pc500 flags0", id_valid, id_pc,
                      {id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_use_imm});
    end
    hold_i = 1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      total++;
      if (sf_dut !== 1'b1 || dut_vec() !== snap) begin
        bad++; $display("FAIL hold_stable c%0d: got sf%b %h want sf1 %h", c, sf_dut, dut_vec(), snap);
      end
    end
    hold_i = 0;
    cycle();
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h504 || id_is_branch !== 1'b1 ||
        id_imm !== 32'hFFFF_FFFC || id_use_imm !== 1'b1 || id_reg_write !== 1'b0) begin
      bad++; $display("FAIL hold_branch: got v%b pc%h br%b imm%h ui%b rw%b want v1 pc504 br1 immfffffffc ui1 rw0",
                      id_valid, id_pc, id_is_branch, id_imm, id_use_imm, id_reg_write);
    end
    cycle();
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h508 ||
        {id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_use_imm} !== 5'b0) begin
      bad++; $display("FAIL hold_nop_after: got v%b pc%h flags%b want v1 pc508 flags0", id_valid, id_pc,
                      {id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_use_imm});
    end
  endtask

  task automatic test_reset_mid_stall();
    restart(32'h600, 3);
    prog[0] = mk(7'b1000000, 4'd2, 4'd1, 4'd0, 13'd4);
    prog[1] = mk(7'b1000001, 4'd0, 4'd2, 4'd5, 13'd8);
    prog[2] = mk(7'b0000000, 4'd6, 4'd1, 4'd1, 13'd0);
    cycle();
    cycle();
    rst_i = 1;
    cycle();
    rst_i = 0;
    total++;
    if (dut_vec() !== exp_t'(0)) begin
      bad++; $display("FAIL reset_mid_stall_clear: got %h want 0", dut_vec());
    end
    cycle();
    total++;
    if (sf_dut !== 1'b0 || id_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid_stall_nostale: got sf%b v%b want sf0 v0", sf_dut, id_valid);
    end
    cycle();
    total++;
    if (sf_dut !== 1'b0 || dut_vec() !== decode(32'h608, prog[2])) begin
      bad++; $display("FAIL reset_mid_stall_resume: got sf%b %h want sf0 %h", sf_dut, dut_vec(), decode(32'h608, prog[2]));
    end
  endtask

  task automatic test_random();
    int cls;
    logic [6:0] op;
    restart(32'h1000, 64);
    for (int i = 0; i < 64; i++) begin
      cls = $urandom_range(0, 3);
      if (cls == 3) op = {4'b1100, 3'($urandom)};
      else op = {2'(cls), 5'($urandom)};
      prog[i] = mk(op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 13'($urandom));
    end
    for (int c = 0; c < 400; c++) begin
      fv_i   = ($urandom_range(0, 99) < 85);
      ovr_i  = ($urandom_range(0, 99) < 4);
      hold_i = ($urandom_range(0, 99) < 10);
      cycle();
      total++;
      if (sf_dut !== sf_exp) begin
        bad++; $display("FAIL rand_stall c%0d: got %b want %b", c, sf_dut, sf_exp);
      end
      total++;
      if (dut_vec() !== m_id) begin
        bad++; $display("FAIL rand_idex c%0d: got %h want %h", c, dut_vec(), m_id);
      end
      if (ovr_i) f_idx = $urandom_range(0, 63);
      if (f_idx >= f_len) f_idx = 0;
    end
    ovr_i = 0; hold_i = 0; fv_i = 1;
  endtask

  initial begin
    m_id = '0; m_ifv = 0; m_ifpc = '0; m_ifinstr = '0;
    rst_i = 1; ovr_i = 0; hold_i = 0; fv_i = 0;
    f_idx = 0; f_len = 0; f_base = '0;
    for (int i = 0; i < 64; i++) prog[i] = '0;
    test_reset();
    test_alu_imm();
    test_load_use();
    test_load_r0();
    test_override_in_stall();
    test_hold_nop_b();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
